// File: rtl/das_beamformer_pkg.sv
// Shared types and arithmetic helpers for the delay-and-sum beamformer.
// Accumulator width and the shift/clamp step are common to every configuration.
package das_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  function automatic int acc_w(input int bw, input int nm);
    return bw + $clog2(nm);
  endfunction

  localparam int ACC_W = acc_w(16, 9);

  // Arithmetic shift then clamp into a signed bw-bit range; wide enough for any sane config.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] v,
                                                   input int shift, input int bw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> shift;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/das_beamformer_if.sv
// Frame, delay-table and result signals of the beamformer grouped as one bus.
interface das_beamformer_if #(
  parameter int BIT_WIDTH   = 16,
  parameter int NUM_MICS    = 9,
  parameter int DELAY_DEPTH = 256
);
  localparam int MIC_W = $clog2(NUM_MICS);
  localparam int AW    = $clog2(DELAY_DEPTH);

  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_in;
  logic                          dly_wr_en;
  logic [MIC_W-1:0]              dly_wr_mic;
  logic [AW-1:0]                 dly_wr_val;
  logic                          dly_commit;
  logic                          out_valid;
  logic signed [BIT_WIDTH-1:0]   out_data;
  logic                          busy;

  modport master (
    output in_valid, pcm_data_in, dly_wr_en, dly_wr_mic, dly_wr_val, dly_commit,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, pcm_data_in, dly_wr_en, dly_wr_mic, dly_wr_val, dly_commit,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/das_beamformer_mic_delay_ram.sv
// Per-mic circular sample store: one write port, one registered read port.
// The array carries no reset; callers never consume locations they have not written.
module mic_delay_ram #(
  parameter int BIT_WIDTH   = 16,
  parameter int DELAY_DEPTH = 256,
  localparam int AW         = $clog2(DELAY_DEPTH)
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic signed [BIT_WIDTH-1:0] wr_data,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  output logic signed [BIT_WIDTH-1:0] rd_data
);

  logic signed [BIT_WIDTH-1:0] mem [DELAY_DEPTH];
  logic signed [BIT_WIDTH-1:0] rd_data_q;
  logic signed [BIT_WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/das_beamformer.sv
// Delay-and-sum beamformer: stores each frame in per-mic rings, then sums one
// delayed tap per mic sequentially and emits the shifted, saturated result.
module das_beamformer
  import das_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int NUM_MICS    = 9,
  parameter int DELAY_DEPTH = 256,
  parameter int OUT_SHIFT   = 4
) (
  input logic        clk,
  input logic        rst,
  das_beamformer_if.slave bus
);

  localparam int MIC_W = $clog2(NUM_MICS);
  localparam int AW    = $clog2(DELAY_DEPTH);
  localparam int SUM_W = acc_w(BIT_WIDTH, NUM_MICS);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DELAY_DEPTH);

  state_t state_q, state_d;
  logic [AW-1:0]    wp_q, wp_d, base_q, base_d;
  logic [AW:0]      fill_q, fill_d;
  logic [AW-1:0]    shadow_q [NUM_MICS];
  logic [AW-1:0]    shadow_d [NUM_MICS];
  logic [AW-1:0]    active_q [NUM_MICS];
  logic [AW-1:0]    active_d [NUM_MICS];
  logic             pending_q, pending_d;
  logic [MIC_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             vld_p1_q, vld_p1_d;
  logic             zero_p1_q, zero_p1_d;
  logic [MIC_W-1:0] mic_p1_q, mic_p1_d;
  logic signed [SUM_W-1:0]     acc_q, acc_d;
  logic signed [BIT_WIDTH-1:0] out_data_q, out_data_d;

  logic                        accept;
  logic                        rd_en;
  logic [AW-1:0]               rd_addr;
  logic signed [BIT_WIDTH-1:0] rd_data [NUM_MICS];
  logic signed [BIT_WIDTH-1:0] tap;

  function automatic logic signed [BIT_WIDTH-1:0] scale_sat(input logic signed [SUM_W-1:0] v);
    logic signed [63:0] r;
    r = shift_sat(64'(v), OUT_SHIFT, BIT_WIDTH);
    return r[BIT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACC;
      ACC:     if (rd_cnt_q == MIC_W'(NUM_MICS - 1)) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     state_d = accept ? ACC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are forced inactive for as long as reset is held.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    rd_en         = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:  bus.in_ready = 1'b1;
        ACC:   begin bus.busy = 1'b1; rd_en = 1'b1; end
        DRAIN: bus.busy = 1'b1;
        OUT:   begin bus.in_ready = 1'b1; bus.out_valid = 1'b1; bus.busy = 1'b1; end
        default: ;
      endcase
    end
  end

  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_data = out_data_q;

  // Accept: write pointer, fill level and the shadow->active copy advance together.
  always_comb begin
    wp_d      = wp_q;
    base_d    = base_q;
    fill_d    = fill_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q | bus.dly_commit;
    rd_cnt_d  = rd_cnt_q;
    if (bus.dly_wr_en && (int'(bus.dly_wr_mic) < NUM_MICS))
      shadow_d[bus.dly_wr_mic] = bus.dly_wr_val;
    if (accept) begin
      base_d   = wp_q;
      wp_d     = wp_q + 1'b1;
      rd_cnt_d = '0;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      if (pending_d) begin
        active_d  = shadow_d;
        pending_d = 1'b0;
      end
    end else if (state_q == ACC) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  // Stage p0: read address and "not yet written" flag for mic rd_cnt_q.
  always_comb begin
    rd_addr   = base_q - active_q[rd_cnt_q];
    zero_p1_d = ({1'b0, active_q[rd_cnt_q]} >= fill_q);
    mic_p1_d  = rd_cnt_q;
    vld_p1_d  = rd_en;
  end

  // Stage p1: RAM return is selected by mic, masked and accumulated.
  always_comb begin
    tap = zero_p1_q ? '0 : rd_data[mic_p1_q];
    acc_d = acc_q;
    if (vld_p1_q) acc_d = acc_q + SUM_W'(tap);
    if (accept)   acc_d = '0;
    out_data_d = out_data_q;
    if (state_q == DRAIN) out_data_d = scale_sat(acc_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      base_q     <= '0;
      fill_q     <= '0;
      pending_q  <= 1'b0;
      rd_cnt_q   <= '0;
      vld_p1_q   <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      for (int m = 0; m < NUM_MICS; m++) begin
        shadow_q[m] <= '0;
        active_q[m] <= '0;
      end
    end else begin
      wp_q       <= wp_d;
      base_q     <= base_d;
      fill_q     <= fill_d;
      pending_q  <= pending_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_p1_q   <= vld_p1_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    zero_p1_q <= zero_p1_d;
    mic_p1_q  <= mic_p1_d;
  end

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_ram
    mic_delay_ram #(
      .BIT_WIDTH  (BIT_WIDTH),
      .DELAY_DEPTH(DELAY_DEPTH)
    ) u_ram (
      .clk    (clk),
      .wr_en  (accept),
      .wr_addr(wp_q),
      .wr_data(bus.pcm_data_in[g*BIT_WIDTH +: BIT_WIDTH]),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data[g])
    );
  end

endmodule

// File: tb/tb_das_beamformer.sv
// Scoreboard bench for das_beamformer: a frame-history model predicts each
// output at accept time; outputs are popped and compared as they appear.
module tb_das_beamformer;

  localparam int BW = 16;
  localparam int NM = 9;
  localparam int DD = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  das_beamformer_if #(.BIT_WIDTH(BW), .NUM_MICS(NM), .DELAY_DEPTH(DD)) bus  ();
  das_beamformer_if #(.BIT_WIDTH(BW), .NUM_MICS(NM), .DELAY_DEPTH(DD)) sbus ();

  das_beamformer #(.BIT_WIDTH(BW), .NUM_MICS(NM), .DELAY_DEPTH(DD), .OUT_SHIFT(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  das_beamformer #(.BIT_WIDTH(BW), .NUM_MICS(NM), .DELAY_DEPTH(DD), .OUT_SHIFT(0)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus));

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  int fr [NM];
  int m_hist [DD][NM];
  int m_nfr;
  int m_shadow [NM];
  int m_active [NM];
  bit m_pending;
  int exp_q [$];
  int acc_cyc_q [$];

  function automatic logic [NM*BW-1:0] pack();
    logic [NM*BW-1:0] p;
    p = '0;
    for (int m = 0; m < NM; m++) p[m*BW +: BW] = fr[m][BW-1:0];
    return p;
  endfunction

  function automatic void m_reset();
    m_nfr = 0;
    m_pending = 1'b0;
    for (int m = 0; m < NM; m++) begin m_shadow[m] = 0; m_active[m] = 0; end
    exp_q.delete();
    acc_cyc_q.delete();
  endfunction

  function automatic int m_accept(input int shift);
    longint s;
    int lim;
    s = 0;
    if (m_pending) begin m_active = m_shadow; m_pending = 1'b0; end
    m_hist[m_nfr % DD] = fr;
    m_nfr++;
    lim = (m_nfr > DD) ? DD : m_nfr;
    for (int m = 0; m < NM; m++)
      if (m_active[m] < lim) s += longint'(m_hist[(m_nfr - 1 - m_active[m]) % DD][m]);
    s = s >>> shift;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic step(output bit acc, output bit got, output int val, output int gap);
    bus.pcm_data_in = pack();
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (!rst) begin
      if (bus.dly_wr_en && int'(bus.dly_wr_mic) < NM) m_shadow[bus.dly_wr_mic] = int'(bus.dly_wr_val);
      if (bus.dly_commit) m_pending = 1'b1;
    end
    if (acc) begin exp_q.push_back(m_accept(4)); acc_cyc_q.push_back(ncyc); end
    got = bus.out_valid;
    val = int'(bus.out_data);
    gap = -1;
    if (got && acc_cyc_q.size() > 0) gap = ncyc - acc_cyc_q.pop_front();
    @(negedge clk);
    ncyc++;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return 32'h7fff_ffff;
    return exp_q.pop_front();
  endfunction

  task automatic clear_dly();
    bus.dly_wr_en = 1'b0; bus.dly_wr_mic = '0; bus.dly_wr_val = '0; bus.dly_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; sbus.in_valid = 1'b0;
    clear_dly();
    sbus.dly_wr_en = 1'b0; sbus.dly_wr_mic = '0; sbus.dly_wr_val = '0; sbus.dly_commit = 1'b0;
    sbus.pcm_data_in = '0;
    for (int m = 0; m < NM; m++) fr[m] = 0;
    bus.pcm_data_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_delay(input int mic, input int d, input bit commit);
    bit a, g; int v, gp;
    bus.dly_wr_en = 1'b1; bus.dly_wr_mic = 4'(mic); bus.dly_wr_val = 8'(d); bus.dly_commit = commit;
    step(a, g, v, gp);
    clear_dly();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; sbus.in_valid = 1'b0;
    clear_dly();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_const();
    bit a, g; int v, gp, e; int sent = 0, outs = 0, last = -1;
    do_reset();
    for (int m = 0; m < NM; m++) fr[m] = 100;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 80 && outs < 4; c++) begin
      step(a, g, v, gp);
      if (a) begin sent++; if (sent == 4) bus.in_valid = 1'b0; end
      if (g) begin
        outs++; e = pop_exp();
        n_tests++; if (v !== e) begin n_fail++; $display("FAIL const_value[%0d]: got %0d want %0d", outs, v, e); end
        n_tests++; if (gp !== 11) begin n_fail++; $display("FAIL const_latency[%0d]: got %0d want 11", outs, gp); end
        if (last >= 0) begin
          n_tests++; if (ncyc - 1 - last !== 11) begin n_fail++; $display("FAIL const_period[%0d]: got %0d want 11", outs, ncyc - 1 - last); end
        end
        last = ncyc - 1;
      end
    end
    n_tests++; if (outs != 4) begin n_fail++; $display("FAIL const_timeout: got %0d outputs want 4", outs); end
  endtask

  task automatic test_impulse();
    bit a, g; int v, gp, e; int sent = 0, outs = 0;
    do_reset();
    set_delay(0, 5, 1'b1);
    fr[0] = 1600;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 150 && outs < 8; c++) begin
      step(a, g, v, gp);
      if (a) begin sent++; fr[0] = 0; if (sent == 8) bus.in_valid = 1'b0; end
      if (g) begin
        outs++; e = pop_exp();
        n_tests++; if (v !== e) begin n_fail++; $display("FAIL impulse[%0d]: got %0d want %0d", outs, v, e); end
      end
    end
    n_tests++; if (outs != 8) begin n_fail++; $display("FAIL impulse_timeout: got %0d outputs want 8", outs); end
  endtask

  task automatic test_wrap();
    bit a, g; int v, gp, e; int sent = 0, outs = 0;
    do_reset();
    set_delay(3, 255, 1'b1);
    fr[3] = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 7000 && outs < 600; c++) begin
      step(a, g, v, gp);
      if (a) begin sent++; fr[3] = 16 * sent; if (sent == 600) bus.in_valid = 1'b0; end
      if (g) begin
        outs++; e = pop_exp();
        n_tests++; if (v !== e) begin n_fail++; $display("FAIL wrap[%0d]: got %0d want %0d", outs, v, e); end
      end
    end
    n_tests++; if (outs != 600) begin n_fail++; $display("FAIL wrap_timeout: got %0d outputs want 600", outs); end
  endtask

  task automatic test_sat();
    logic [NM*BW-1:0] pats [2];
    int want [2];
    bit seen;
    pats[0] = {NM{16'h7fff}}; want[0] = 32767;
    pats[1] = {NM{16'h8000}}; want[1] = -32768;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      sbus.pcm_data_in = pats[p];
      sbus.in_valid = 1'b1;
      @(negedge clk);
      sbus.in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (sbus.out_valid) begin
          seen = 1'b1;
          n_tests++; if (int'(sbus.out_data) !== want[p]) begin n_fail++; $display("FAIL sat[%0d]: got %0d want %0d", p, sbus.out_data, want[p]); end
        end
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL sat_timeout[%0d]: got no out_valid want one", p); end
      @(negedge clk);
    end
  endtask

  task automatic test_commit();
    bit a, g; int v, gp, e; int sent = 0, outs = 0;
    do_reset();
    for (int m = 0; m < NM; m++) fr[m] = 16 * m;
    bus.dly_wr_en = 1'b1; bus.dly_wr_mic = 4'd1; bus.dly_wr_val = 8'd2;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 150 && outs < 9; c++) begin
      step(a, g, v, gp);
      clear_dly();
      if (a) begin
        sent++;
        for (int m = 0; m < NM; m++) fr[m] = 16 * (10 * sent + m);
        if (sent == 9) bus.in_valid = 1'b0;
        if (sent == 3) begin bus.dly_wr_en = 1'b1; bus.dly_wr_mic = 4'd9; bus.dly_wr_val = 8'd7; bus.dly_commit = 1'b1; end
        if (sent == 6) begin bus.dly_wr_en = 1'b1; bus.dly_wr_mic = 4'd2; bus.dly_wr_val = 8'd1; bus.dly_commit = 1'b1; end
      end
      if (g) begin
        outs++; e = pop_exp();
        n_tests++; if (v !== e) begin n_fail++; $display("FAIL commit[%0d]: got %0d want %0d", outs, v, e); end
      end
    end
    n_tests++; if (outs != 9) begin n_fail++; $display("FAIL commit_timeout: got %0d outputs want 9", outs); end
  endtask

  task automatic test_rst_mid();
    bit a, g; int v, gp, e; int stray = 0, outs = 0;
    do_reset();
    set_delay(0, 1, 1'b1);
    for (int m = 0; m < NM; m++) fr[m] = 160;
    bus.in_valid = 1'b1;
    step(a, g, v, gp);
    bus.in_valid = 1'b0;
    repeat (4) begin step(a, g, v, gp); if (g) stray++; end
    rst = 1'b1;
    m_reset();
    repeat (2) begin step(a, g, v, gp); if (g) stray++; end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_rst: got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_release: got %b want 1", bus.in_ready); end
    repeat (15) begin step(a, g, v, gp); if (g) stray++; end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_no_out: got %0d strobes want 0", stray); end
    set_delay(0, 1, 1'b1);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 30 && outs < 1; c++) begin
      step(a, g, v, gp);
      if (a) bus.in_valid = 1'b0;
      if (g) begin
        outs++; e = pop_exp();
        n_tests++; if (v !== e) begin n_fail++; $display("FAIL rstmid_first: got %0d want %0d", v, e); end
      end
    end
    n_tests++; if (outs != 1) begin n_fail++; $display("FAIL rstmid_timeout: got %0d outputs want 1", outs); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.pcm_data_in = '0;
    bus.dly_wr_en = 1'b0; bus.dly_wr_mic = '0; bus.dly_wr_val = '0; bus.dly_commit = 1'b0;
    sbus.in_valid = 1'b0; sbus.pcm_data_in = '0;
    sbus.dly_wr_en = 1'b0; sbus.dly_wr_mic = '0; sbus.dly_wr_val = '0; sbus.dly_commit = 1'b0;
    @(negedge clk);
    test_reset();
    test_const();
    test_impulse();
    test_wrap();
    test_sat();
    test_commit();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
